// File: rtl/uart_rx_toggle.sv
// rtl/uart_rx_toggle.sv - 8N1 UART receiver signalling each byte by toggling dataAvail
// Optional feature macro UART_RX_PARITY_EN: 8E1 framing with a PARITY state and a parityErr output.
module uart_rx_toggle #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int CNT_W        = 16
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] data,
    output logic       dataAvail,
`ifdef UART_RX_PARITY_EN
    output logic       parityErr,
`endif
    output logic       frameErr
);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t           state, state_n;
    logic             sync1, rxs;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             avail_n;
    logic             ferr_n;
    logic             deliver;

`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_n;
    logic             perr_n;
    assign deliver = rxs && !par_bad;
`else
    assign deliver = rxs;
`endif

    // Two-flop synchroniser; decoding only ever looks at rxs.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= RX;
            rxs   <= sync1;
        end
    end

    // Frame decoder state register and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            dataAvail <= 1'b0;
            frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            dataAvail <= avail_n;
            frameErr  <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_n;
            parityErr <= perr_n;
`endif
        end
    end

    // Next-state logic: mid-bit sampling driven by the bit-period counter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        avail_n = dataAvail;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_n = '0;
                    if (!rxs) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end else begin
                        // Start bit gone by its centre: a glitch, not a frame.
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n        = '0;
                    shift_n[idx] = rxs;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_END) begin
                    cnt_n     = '0;
                    par_bad_n = (^shift) ^ rxs;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                    perr_n = par_bad;
`endif
                    if (deliver) begin
                        data_n  = shift;
                        avail_n = ~dataAvail;
                    end
                    if (rxs) begin
                        // Back to IDLE at stop centre leaves half a bit to catch the next start.
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                // Held-low line must not decode as a stream of 0x00 bytes.
                cnt_n = '0;
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
